// File: rtl/tx_serializer.sv
// 10-bit MSB-first serializer with a one-word holding register. Word slots with no
// pending data are filled with K28.5, picked by the running disparity.
module tx_serializer #(
  parameter logic [9:0] IDLE_NEG = 10'b0011111010,
  parameter logic [9:0] IDLE_POS = 10'b1100000101
) (
  input  logic       BitCLK,
  input  logic       Reset,
  input  logic [9:0] TxParallel_10,
  input  logic       TxValid_10,
  output logic       TxReady_10,
  output logic       TxSerial,
  output logic       TxIdle,
  output logic       DispErr
);

  logic [9:0] shreg_q, shreg_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       rd_q, rd_d;
  logic       idle_q, idle_d;
  logic       disp_err_q, disp_err_d;

  logic       boundary;
  logic       accept;
  logic [9:0] load_word;
  logic [3:0] load_ones;

  function automatic logic [3:0] ones_of(input logic [9:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n;
  endfunction

  assign boundary   = (cnt_q == 4'd9);
  assign accept     = TxValid_10 && !hold_valid_q;
  assign load_word  = hold_valid_q ? hold_q : (rd_q ? IDLE_POS : IDLE_NEG);
  assign load_ones  = ones_of(load_word);

  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rd_d         = rd_q;
    idle_d       = idle_q;
    disp_err_d   = 1'b0;

    // A word captured on a boundary edge finds hold empty, so the idle wins this slot.
    if (accept) begin
      hold_d       = TxParallel_10;
      hold_valid_d = 1'b1;
    end

    if (boundary) begin
      cnt_d   = 4'd0;
      shreg_d = load_word;
      idle_d  = !hold_valid_q;
      if (hold_valid_q) begin
        hold_valid_d = 1'b0;
      end
      if (load_ones == 4'd6) begin
        rd_d = 1'b1;
      end else if (load_ones == 4'd4) begin
        rd_d = 1'b0;
      end else if (load_ones != 4'd5) begin
        disp_err_d = 1'b1;
      end
    end else begin
      cnt_d   = cnt_q + 4'd1;
      shreg_d = {shreg_q[8:0], 1'b0};
    end
  end

  always_ff @(posedge BitCLK) begin
    if (Reset) begin
      shreg_q      <= IDLE_NEG;
      cnt_q        <= 4'd0;
      hold_q       <= 10'd0;
      hold_valid_q <= 1'b0;
      rd_q         <= 1'b1;
      idle_q       <= 1'b1;
      disp_err_q   <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rd_q         <= rd_d;
      idle_q       <= idle_d;
      disp_err_q   <= disp_err_d;
    end
  end

  assign TxReady_10 = !hold_valid_q;
  assign TxSerial   = shreg_q[9];
  assign TxIdle     = idle_q;
  assign DispErr    = disp_err_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: a word-slot vector table followed by hand-written
// back-to-back and reset-mid-word sequences.
module tb_tx_serializer;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;

  logic       BitCLK = 1'b0;
  logic       Reset;
  logic [9:0] TxParallel_10;
  logic       TxValid_10;
  logic       TxReady_10;
  logic       TxSerial;
  logic       TxIdle;
  logic       DispErr;

  int cmp_cnt = 0;
  int err_cnt = 0;

  tx_serializer #(.IDLE_NEG(K_NEG), .IDLE_POS(K_POS)) dut (
    .BitCLK        (BitCLK),
    .Reset         (Reset),
    .TxParallel_10 (TxParallel_10),
    .TxValid_10    (TxValid_10),
    .TxReady_10    (TxReady_10),
    .TxSerial      (TxSerial),
    .TxIdle        (TxIdle),
    .DispErr       (DispErr)
  );

  always #5 BitCLK = ~BitCLK;

  typedef struct {
    logic       offer;
    logic [3:0] at;
    logic [9:0] data;
    logic [9:0] exp_word;
    logic       exp_idle;
    logic       exp_derr;
  } vec_t;

  vec_t tbl [19];

  task automatic tick();
    @(posedge BitCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " serial"}, {31'd0, TxSerial},   32'd0);
    check({tag, " ready"},  {31'd0, TxReady_10}, 32'd1);
    check({tag, " idle"},   {31'd0, TxIdle},     32'd1);
    check({tag, " derr"},   {31'd0, DispErr},    32'd0);
  endtask

  logic [9:0] ser, idl, der, rdy;
  logic [9:0] bb_ser [7];
  logic [9:0] bb_idl [7];
  logic [9:0] bb_der [7];
  logic [9:0] bb_rdy [7];
  logic [9:0] words  [5];
  int         idx;
  logic       cap;

  initial begin
    // slot: offer, at, data, expected word, expected TxIdle, expected DispErr
    tbl[0]  = '{1'b0, 4'd0, 10'd0,          K_NEG,          1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'd0, 10'd0,          K_POS,          1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'd0, 10'd0,          K_NEG,          1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'd2, 10'b0101111100, K_POS,          1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 10'd0,          10'b0101111100, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 10'd0,          K_POS,          1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'd5, 10'b1010101010, K_NEG,          1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 10'd0,          10'b1010101010, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd8, 10'b1111111111, K_POS,          1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 10'd0,          10'b1111111111, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'd9, 10'b0110001011, K_NEG,          1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 10'd0,          K_POS,          1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 10'd0,          10'b0110001011, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'd0, 10'b0000000111, K_NEG,          1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'd0, 10'd0,          10'b0000000111, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 4'd0, 10'd0,          K_POS,          1'b1, 1'b0};
    tbl[16] = '{1'b1, 4'd3, 10'b1000110001, K_NEG,          1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'd0, 10'd0,          10'b1000110001, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 4'd0, 10'd0,          K_NEG,          1'b1, 1'b0};

    words[0] = 10'b0101010101;
    words[1] = 10'b1100110011;
    words[2] = 10'b0011001100;
    words[3] = 10'b1110001100;
    words[4] = 10'b0101100110;

    Reset         = 1'b1;
    TxValid_10    = 1'b0;
    TxParallel_10 = 10'd0;
    tick();
    tick();
    tick();
    check_reset_outputs("reset");
    Reset = 1'b0;

    // Each slot starts with its first bit on the line.
    for (int i = 0; i < 19; i++) begin
      for (int s = 0; s < 10; s++) begin
        ser[9-s] = TxSerial;
        idl[9-s] = TxIdle;
        der[9-s] = DispErr;
        if (tbl[i].offer && (s == int'(tbl[i].at))) begin
          TxValid_10    = 1'b1;
          TxParallel_10 = tbl[i].data;
          tick();
          TxValid_10    = 1'b0;
          check($sformatf("slot%0d ready_after_capture", i), {31'd0, TxReady_10}, 32'd0);
        end else begin
          tick();
        end
      end
      check($sformatf("slot%0d word", i), {22'd0, ser}, {22'd0, tbl[i].exp_word});
      check($sformatf("slot%0d idle", i), {22'd0, idl}, {22'd0, {10{tbl[i].exp_idle}}});
      check($sformatf("slot%0d derr", i), {22'd0, der}, {22'd0, tbl[i].exp_derr, 9'd0});
    end

    // Back-to-back: valid held high across five words.
    idx           = 0;
    TxValid_10    = 1'b1;
    TxParallel_10 = words[0];
    for (int k = 0; k < 7; k++) begin
      for (int s = 0; s < 10; s++) begin
        bb_ser[k][9-s] = TxSerial;
        bb_idl[k][9-s] = TxIdle;
        bb_der[k][9-s] = DispErr;
        bb_rdy[k][9-s] = TxReady_10;
        cap = TxValid_10 && TxReady_10;
        tick();
        if (cap) begin
          idx++;
          if (idx == 5) TxValid_10 = 1'b0;
          else          TxParallel_10 = words[idx];
        end
      end
    end
    check("b2b accepted", idx, 5);
    check("b2b lead idle word", {22'd0, bb_ser[0]}, {22'd0, K_POS});
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("b2b word%0d", k - 1), {22'd0, bb_ser[k]}, {22'd0, words[k-1]});
      check($sformatf("b2b idle%0d", k - 1), {22'd0, bb_idl[k]}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b ready%0d", k), {22'd0, bb_rdy[k]}, {22'd0, 10'b1000000000});
    end
    for (int k = 0; k < 7; k++) begin
      check($sformatf("b2b derr%0d", k), {22'd0, bb_der[k]}, 32'd0);
    end
    check("b2b trailing idle word", {22'd0, bb_ser[6]}, {22'd0, K_NEG});

    // Reset at cnt = 4 with a word waiting in hold.
    TxValid_10    = 1'b1;
    TxParallel_10 = 10'b1110000011;
    tick();
    TxValid_10 = 1'b0;
    tick();
    tick();
    tick();
    check("midword hold_full", {31'd0, TxReady_10}, 32'd0);
    Reset = 1'b1;
    tick();
    check_reset_outputs("midreset1");
    tick();
    check_reset_outputs("midreset2");
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 10; s++) begin
        ser[9-s] = TxSerial;
        idl[9-s] = TxIdle;
        rdy[9-s] = TxReady_10;
        tick();
      end
      check($sformatf("post_reset word%0d", k), {22'd0, ser},
            {22'd0, ((k % 2) == 0) ? K_NEG : K_POS});
      check($sformatf("post_reset idle%0d", k), {22'd0, idl}, {22'd0, 10'h3FF});
      check($sformatf("post_reset ready%0d", k), {22'd0, rdy}, {22'd0, 10'h3FF});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
